gaussian_level_blur: RTL and testbench

//  Parametrised 3x3 Gaussian blur engine for one pyramid level (octave 0..LEVELS-1).

---
 rtl/gaussian_level_blur.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_gaussian_level_blur.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_level_blur.sv
// 3x3 Gaussian blur ([1 2 1]x[1 2 1]/16) for one pyramid octave.
// Reads the source through a fixed-latency BRAM port with edge clamping and
// writes each blurred pixel to a destination port with backpressure.
// Optional feature: define GAUSS_DOWNSAMPLE_EN to add a 2:1 decimated output
// stream (ds_*) stored after the full-size image.
module gaussian_level_blur #(
  parameter int unsigned BIT_DEPTH    = 8,
  parameter int unsigned IMG_WIDTH    = 128,
  parameter int unsigned IMG_HEIGHT   = 128,
  parameter int unsigned LEVELS       = 4,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned READ_LATENCY = 2,
  localparam int unsigned LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [LVL_W-1:0]     level_in,
  input  logic [ADDR_W-1:0]    src_base_in,
  input  logic [ADDR_W-1:0]    dst_base_in,
  output logic [ADDR_W-1:0]    rd_addr_out,
  output logic                 rd_en_out,
  input  logic [BIT_DEPTH-1:0] rd_data_in,
  output logic [ADDR_W-1:0]    wr_addr_out,
  output logic [BIT_DEPTH-1:0] wr_data_out,
  output logic                 wr_valid_out,
  input  logic                 wr_ready_in,
  output logic                 busy_out,
  output logic                 done_out,
`ifdef GAUSS_DOWNSAMPLE_EN
  output logic [ADDR_W-1:0]    ds_addr_out,
  output logic [BIT_DEPTH-1:0] ds_data_out,
  output logic                 ds_valid_out,
`endif
  output logic                 error_out
);

  localparam int unsigned XW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned YW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned SHW   = $clog2(XW + 1);
  localparam int unsigned SUM_W = BIT_DEPTH + 4;
  localparam int unsigned DCW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_ACC, S_WRITE, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              tap_q, tap_d;
  logic [3:0]              rx_q, rx_d;
  logic [DCW-1:0]          drain_q, drain_d;
  logic [READ_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [XW-1:0]           x_q, x_d, xmax_q, xmax_d;
  logic [YW-1:0]           y_q, y_d, ymax_q, ymax_d;
  logic [SHW-1:0]          wsh_q, wsh_d;
  logic [ADDR_W-1:0]       src_base_q, src_base_d, dst_base_q, dst_base_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [BIT_DEPTH-1:0]    wr_data_q, wr_data_d;
  logic                    rd_en_q, rd_en_d, wr_valid_q, wr_valid_d;
  logic                    busy_q, busy_d, done_q, done_d, error_q, error_d;
`ifdef GAUSS_DOWNSAMPLE_EN
  logic                    ds_en_q, ds_en_d, ds_valid_q, ds_valid_d;
  logic [ADDR_W-1:0]       ds_addr_q, ds_addr_d;
  logic [BIT_DEPTH-1:0]    ds_data_q, ds_data_d;
`endif

  logic       lvl_ok;
  logic [1:0] dyi, dxi, wsel;
  logic [XW-1:0] xs;
  logic [YW-1:0] ys;

  assign lvl_ok = (32'(level_in) < LEVELS);

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    tap_d      = 4'd0;
    rx_d       = rx_q;
    drain_d    = drain_q;
    vpipe_d    = (vpipe_q << 1) | READ_LATENCY'(rd_en_q);
    sum_d      = sum_q;
    x_d        = x_q;
    y_d        = y_q;
    xmax_d     = xmax_q;
    ymax_d     = ymax_q;
    wsh_d      = wsh_q;
    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = wr_valid_q;
    error_d    = 1'b0;
    rd_addr_d  = '0;
    dyi        = 2'd1;
    dxi        = 2'd1;
    wsel       = 2'd0;
    xs         = '0;
    ys         = '0;
`ifdef GAUSS_DOWNSAMPLE_EN
    ds_en_d    = ds_en_q;
    ds_valid_d = 1'b0;
    ds_addr_d  = ds_addr_q;
    ds_data_d  = ds_data_q;
`endif

    if (state_q == S_FETCH) tap_d = tap_q + 4'd1;

    // Accumulate a returning tap; weight shift 0/1/2 for corner/edge/centre
    if (vpipe_q[READ_LATENCY-1]) begin
      case (rx_q)
        4'd4:                      wsel = 2'd2;
        4'd1, 4'd3, 4'd5, 4'd7:    wsel = 2'd1;
        default:                   wsel = 2'd0;
      endcase
      sum_d = sum_q + (SUM_W'(rd_data_in) << wsel);
      rx_d  = rx_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          if (lvl_ok) begin
            state_d    = S_FETCH;
            src_base_d = src_base_in;
            dst_base_d = dst_base_in;
            xmax_d     = XW'((IMG_WIDTH >> level_in) - 1);
            ymax_d     = YW'((IMG_HEIGHT >> level_in) - 1);
            wsh_d      = SHW'(XW - 32'(level_in));
            x_d        = '0;
            y_d        = '0;
            sum_d      = '0;
            rx_d       = 4'd0;
`ifdef GAUSS_DOWNSAMPLE_EN
            ds_en_d    = (32'(level_in) != LEVELS - 1);
`endif
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (tap_q == 4'd8) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        if (drain_q == DCW'(READ_LATENCY - 1)) state_d = S_ACC;
        else drain_d = drain_q + DCW'(1);
      end
      S_ACC: begin
        wr_data_d  = BIT_DEPTH'((sum_q + SUM_W'(8)) >> 4);
        wr_addr_d  = dst_base_q + (ADDR_W'(y_q) << wsh_q) + ADDR_W'(x_q);
        wr_valid_d = 1'b1;
        sum_d      = '0;
        rx_d       = 4'd0;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (wr_ready_in) begin
          wr_valid_d = 1'b0;
`ifdef GAUSS_DOWNSAMPLE_EN
          if (ds_en_q && !x_q[0] && !y_q[0]) begin
            ds_valid_d = 1'b1;
            ds_data_d  = wr_data_q;
            ds_addr_d  = dst_base_q
                       + ((ADDR_W'(ymax_q) + ADDR_W'(1)) << wsh_q)
                       + ((ADDR_W'(y_q >> 1) << wsh_q) >> 1)
                       + ADDR_W'(x_q >> 1);
          end
`endif
          if (x_q == xmax_q && y_q == ymax_q) begin
            state_d = S_DONE;
            x_d     = '0;
            y_d     = '0;
          end else begin
            state_d = S_FETCH;
            if (x_q == xmax_q) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Read address for the tap issued next cycle, clamped to the image
    case (tap_d)
      4'd0: {dyi, dxi} = {2'd0, 2'd0};
      4'd1: {dyi, dxi} = {2'd0, 2'd1};
      4'd2: {dyi, dxi} = {2'd0, 2'd2};
      4'd3: {dyi, dxi} = {2'd1, 2'd0};
      4'd4: {dyi, dxi} = {2'd1, 2'd1};
      4'd5: {dyi, dxi} = {2'd1, 2'd2};
      4'd6: {dyi, dxi} = {2'd2, 2'd0};
      4'd7: {dyi, dxi} = {2'd2, 2'd1};
      4'd8: {dyi, dxi} = {2'd2, 2'd2};
      default: {dyi, dxi} = {2'd1, 2'd1};
    endcase
    case (dxi)
      2'd0:    xs = (x_d == '0) ? x_d : x_d - XW'(1);
      2'd2:    xs = (x_d == xmax_d) ? x_d : x_d + XW'(1);
      default: xs = x_d;
    endcase
    case (dyi)
      2'd0:    ys = (y_d == '0) ? y_d : y_d - YW'(1);
      2'd2:    ys = (y_d == ymax_d) ? y_d : y_d + YW'(1);
      default: ys = y_d;
    endcase

    rd_en_d = (state_d == S_FETCH);
    if (rd_en_d) rd_addr_d = src_base_d + (ADDR_W'(ys) << wsh_d) + ADDR_W'(xs);
    busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN) ||
             (state_d == S_ACC) || (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      tap_q      <= 4'd0;
      rx_q       <= 4'd0;
      drain_q    <= '0;
      vpipe_q    <= '0;
      sum_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      xmax_q     <= '0;
      ymax_q     <= '0;
      wsh_q      <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef GAUSS_DOWNSAMPLE_EN
      ds_en_q    <= 1'b0;
      ds_valid_q <= 1'b0;
      ds_addr_q  <= '0;
      ds_data_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      rx_q       <= rx_d;
      drain_q    <= drain_d;
      vpipe_q    <= vpipe_d;
      sum_q      <= sum_d;
      x_q        <= x_d;
      y_q        <= y_d;
      xmax_q     <= xmax_d;
      ymax_q     <= ymax_d;
      wsh_q      <= wsh_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      rd_addr_q  <= rd_addr_d;
      rd_en_q    <= rd_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef GAUSS_DOWNSAMPLE_EN
      ds_en_q    <= ds_en_d;
      ds_valid_q <= ds_valid_d;
      ds_addr_q  <= ds_addr_d;
      ds_data_q  <= ds_data_d;
`endif
    end
  end

  assign rd_addr_out  = rd_addr_q;
  assign rd_en_out    = rd_en_q;
  assign wr_addr_out  = wr_addr_q;
  assign wr_data_out  = wr_data_q;
  assign wr_valid_out = wr_valid_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign error_out    = error_q;
`ifdef GAUSS_DOWNSAMPLE_EN
  assign ds_addr_out  = ds_addr_q;
  assign ds_data_out  = ds_data_q;
  assign ds_valid_out = ds_valid_q;
`endif

endmodule

// File: tb/tb_gaussian_level_blur.sv
// Self-checking bench for gaussian_level_blur: 8x8 image, LEVELS=3, 2-cycle BRAM.
module tb_gaussian_level_blur;
  localparam int AW = 15;
  localparam int BD = 8;
  localparam int RL = 2;
  localparam int LW = 2;
  localparam int SRC = 256;
  localparam int DST = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_in = 1'b0;
  logic [LW-1:0] level_in = '0;
  logic [AW-1:0] src_base_in = AW'(SRC);
  logic [AW-1:0] dst_base_in = AW'(DST);
  logic [AW-1:0] rd_addr_out, wr_addr_out;
  logic          rd_en_out, wr_valid_out, busy_out, done_out, error_out;
  logic [BD-1:0] rd_data_in, wr_data_out;
  logic          wr_ready_in = 1'b1;
`ifdef GAUSS_DOWNSAMPLE_EN
  logic [AW-1:0] ds_addr_out;
  logic [BD-1:0] ds_data_out;
  logic          ds_valid_out;
`endif

  gaussian_level_blur #(
    .BIT_DEPTH(BD), .IMG_WIDTH(8), .IMG_HEIGHT(8), .LEVELS(3),
    .ADDR_W(AW), .READ_LATENCY(RL)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_in), .level_in(level_in),
    .src_base_in(src_base_in), .dst_base_in(dst_base_in),
    .rd_addr_out(rd_addr_out), .rd_en_out(rd_en_out), .rd_data_in(rd_data_in),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .wr_valid_out(wr_valid_out), .wr_ready_in(wr_ready_in),
    .busy_out(busy_out), .done_out(done_out),
`ifdef GAUSS_DOWNSAMPLE_EN
    .ds_addr_out(ds_addr_out), .ds_data_out(ds_data_out), .ds_valid_out(ds_valid_out),
`endif
    .error_out(error_out)
  );

  always #5 clk = ~clk;

  // Source BRAM: data appears RL cycles after the read request
  logic [BD-1:0] mem [0:32767];
  logic [BD-1:0] rpipe [RL];
  always @(posedge clk) begin
    if (rd_en_out) rpipe[0] <= mem[rd_addr_out];
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign rd_data_in = rpipe[RL-1];

  int total = 0;
  int bad = 0;
  int wa_q[$];
  int wd_q[$];
  int da_q[$];
  int dd_q[$];
  int done_cnt, done_cyc, busy_cyc, post_busy, hold_bad;
  int out_px [64];

  typedef struct {int img; int x; int y; int exp;} vec_t;
  vec_t tab [14];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int any_out();
    int r;
    r = int'(rd_en_out | busy_out | done_out | error_out | wr_valid_out |
              (|rd_addr_out) | (|wr_addr_out) | (|wr_data_out));
`ifdef GAUSS_DOWNSAMPLE_EN
    r = r | int'(ds_valid_out | (|ds_addr_out) | (|ds_data_out));
`endif
    return r;
  endfunction

  // Straight 2D convolution with clamped borders over the source image
  function automatic int gold(int x, int y, int w, int h);
    int s, xs, ys;
    s = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xs = x + dx; ys = y + dy;
        if (xs < 0) xs = 0;
        if (xs > w - 1) xs = w - 1;
        if (ys < 0) ys = 0;
        if (ys > h - 1) ys = h - 1;
        s += int'(mem[SRC + ys*w + xs]) * ((dx == 0) ? 2 : 1) * ((dy == 0) ? 2 : 1);
      end
    end
    return (s + 8) / 16;
  endfunction

  task automatic set_img(input int kind);
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0: mem[SRC+i] = 8'd100;
        1: mem[SRC+i] = (i == 3*8+3) ? 8'd255 : 8'd0;
        2: mem[SRC+i] = (i == 0) ? 8'd160 : 8'd0;
        default: mem[SRC+i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // One pass with optional 5-cycle stall on pixel stall_pix and ignored start pokes
  task automatic run_pass(input int lv, input int stall_pix, input bit poke);
    int stall_left;
    bit stalled;
    logic [AW-1:0] h_addr;
    logic [BD-1:0] h_data;
    stall_left = 0; stalled = 1'b0; h_addr = '0; h_data = '0;
    wa_q.delete(); wd_q.delete(); da_q.delete(); dd_q.delete();
    done_cnt = 0; done_cyc = -1; busy_cyc = 0; post_busy = 0; hold_bad = 0;
    level_in = LW'(lv); start_in = 1'b1; wr_ready_in = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      start_in = 1'b0;
      if (busy_out) begin
        if (done_cyc < 0) busy_cyc++; else post_busy++;
      end
      if (done_out) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          if (poke) begin start_in = 1'b1; level_in = '0; end
        end
      end
      if (poke && cyc == 100) start_in = 1'b1;
`ifdef GAUSS_DOWNSAMPLE_EN
      if (ds_valid_out) begin da_q.push_back(int'(ds_addr_out)); dd_q.push_back(int'(ds_data_out)); end
`endif
      if (stall_left > 0) begin
        wr_ready_in = 1'b0;
        stall_left--;
        if (!wr_valid_out || wr_addr_out !== h_addr || wr_data_out !== h_data) hold_bad++;
      end else if (stall_pix >= 0 && !stalled && wr_valid_out && wa_q.size() == stall_pix) begin
        stalled = 1'b1; stall_left = 4;
        h_addr = wr_addr_out; h_data = wr_data_out;
        wr_ready_in = 1'b0;
      end else begin
        wr_ready_in = 1'b1;
      end
      if (wr_valid_out && wr_ready_in) begin
        wa_q.push_back(int'(wr_addr_out));
        wd_q.push_back(int'(wr_data_out));
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 6) break;
      @(posedge clk); #1;
    end
    start_in = 1'b0; wr_ready_in = 1'b1;
  endtask

  task automatic check_pass(input string tag, input int w, input int h, input int exp_cyc);
    int abad, dbad;
    abad = 0; dbad = 0;
    check({tag, "_count"}, wa_q.size(), w*h);
    for (int i = 0; i < wa_q.size(); i++) begin
      if (wa_q[i] != DST + i) abad++;
      if (i < w*h && wd_q[i] != gold(i % w, i / w, w, h)) dbad++;
      if (i < 64) out_px[i] = wd_q[i];
    end
    check({tag, "_addr_order"}, abad, 0);
    check({tag, "_data"}, dbad, 0);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_cyc, exp_cyc);
  endtask

  initial begin
    int nz, n100;
    tab[0]  = '{1, 3, 3, 64};  tab[1]  = '{1, 2, 3, 32};  tab[2]  = '{1, 3, 2, 32};
    tab[3]  = '{1, 2, 2, 16};  tab[4]  = '{1, 4, 4, 16};  tab[5]  = '{1, 4, 3, 32};
    tab[6]  = '{1, 0, 0, 0};   tab[7]  = '{1, 6, 6, 0};   tab[8]  = '{2, 0, 0, 90};
    tab[9]  = '{2, 1, 0, 30};  tab[10] = '{2, 0, 1, 30};  tab[11] = '{2, 1, 1, 10};
    tab[12] = '{2, 2, 0, 0};   tab[13] = '{2, 2, 2, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", any_out(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Constant image: 64 writes of 100, done once, 64*13 busy cycles
    set_img(0);
    run_pass(0, -1, 1'b1);
    check_pass("const", 8, 8, 64*13);
    n100 = 0;
    foreach (wd_q[i]) if (wd_q[i] == 100) n100++;
    check("const_all_100", n100, 64);
    check("const_busy_cycles", busy_cyc, 64*13);
    check("const_busy_after_done", post_busy, 0);
`ifdef GAUSS_DOWNSAMPLE_EN
    check("ds_count", da_q.size(), 16);
    nz = 0;
    foreach (da_q[i]) if (da_q[i] != DST + 64 + i || dd_q[i] != 100) nz++;
    check("ds_addr_data", nz, 0);
`endif

    // Impulse and corner images against hand-computed table
    for (int img = 1; img <= 2; img++) begin
      set_img(img);
      run_pass(0, -1, 1'b0);
      check_pass((img == 1) ? "impulse" : "corner", 8, 8, 64*13);
      for (int k = 0; k < 14; k++)
        if (tab[k].img == img)
          check($sformatf("px_img%0d_x%0d_y%0d", img, tab[k].x, tab[k].y),
                out_px[tab[k].y*8 + tab[k].x], tab[k].exp);
      nz = 0;
      for (int i = 0; i < 64; i++) if (out_px[i] != 0) nz++;
      check((img == 1) ? "impulse_nonzero" : "corner_nonzero", nz, (img == 1) ? 9 : 4);
    end

    // Backpressure: ready low 5 cycles on pixel 10
    set_img(3);
    run_pass(0, 10, 1'b0);
    check_pass("stall", 8, 8, 64*13 + 5);
    check("stall_hold", hold_bad, 0);

    // Level 1: 4x4, row stride 4
    run_pass(1, -1, 1'b0);
    check_pass("level1", 4, 4, 16*13);

    // Invalid level: error pulse next cycle, no pass
    level_in = 2'd3; start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    check("err_pulse", int'(error_out), 1);
    check("err_busy", int'(busy_out), 0);
    @(posedge clk); #1;
    check("err_pulse_end", int'(error_out), 0);
    check("err_no_read", int'(busy_out | rd_en_out), 0);

    // Asynchronous reset mid-pass, then a clean pass
    level_in = '0; start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (200) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("abort_outputs", any_out(), 0);
    repeat (2) @(posedge clk);
    #1 check("abort_held", any_out(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_pass(0, -1, 1'b0);
    check_pass("after_abort", 8, 8, 64*13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
